// File: rtl/adder_pkg.sv
// Shared constants for the registered 8-bit adder.
// Holds the datapath width and the output reset values.
package adder_pkg;

    localparam int ADD_W = 8;

    localparam logic [ADD_W-1:0] SUM_RST = 8'h00;
    localparam logic CARRY_RST = 1'b0;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the cell of the ripple chain.
// Purely combinational.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = x ^ y;
    assign s    = p ^ cin;
    assign cout = (x & y) | (cin & p);

endmodule

// File: rtl/eight_bit_adder.sv
// Registered 8-bit unsigned adder: ripple chain of full adders
// feeding a single output register stage with carry-out.
module eight_bit_adder
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [ADD_W-1:0] sum,
    output logic             finalcarry
);

    logic [ADD_W:0]   c;
    logic [ADD_W-1:0] s;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < ADD_W; i++) begin : g_rca
        full_adder u_fa (
            .x    (a[i]),
            .y    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Capture the ripple result every edge; reset clears without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum        <= SUM_RST;
            finalcarry <= CARRY_RST;
        end else begin
            sum        <= s;
            finalcarry <= c[ADD_W];
        end
    end

endmodule

// File: tb/tb_eight_bit_adder.sv
// Directed and exhaustive check of eight_bit_adder,
// including async reset and the one-cycle output lag.
module tb_eight_bit_adder;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       finalcarry;

    int n_cmp;
    int n_bad;

    logic [8:0] exp_q;

    logic [7:0] va [5] = '{8'd0, 8'd100, 8'd255, 8'd255, 8'd128};
    logic [7:0] vb [5] = '{8'd0, 8'd27,  8'd1,   8'd255, 8'd127};
    logic [7:0] vs [5] = '{8'd0, 8'd127, 8'd0,   8'd254, 8'd255};
    logic       vc [5] = '{1'b0, 1'b0,   1'b1,   1'b1,   1'b0};

    eight_bit_adder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .sum        (sum),
        .finalcarry (finalcarry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (a=%0d b=%0d) @%0t",
                     tag, got, exp, a, b, $time);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a = 8'hFF;
        b = 8'h01;

        #1;
        chk("rst_async", {finalcarry, sum}, 9'h000);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold", {finalcarry, sum}, 9'h000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_pre", {finalcarry, sum}, 9'h000);
        @(posedge clk);
        #1;
        chk("rst_rel", {finalcarry, sum}, 9'h100);
        exp_q = 9'h100;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = va[i];
            b = vb[i];
            #1;
            chk("dir_lag", {finalcarry, sum}, exp_q);
            @(posedge clk);
            #1;
            exp_q = {vc[i], vs[i]};
            chk("dir", {finalcarry, sum}, exp_q);
        end

        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                @(negedge clk);
                a = 8'(ia);
                b = 8'(ib);
                #1;
                chk("exh_lag", {finalcarry, sum}, exp_q);
                if (ia == 117 && ib == 53) begin
                    rst_n = 1'b0;
                    #1;
                    chk("mid_rst", {finalcarry, sum}, 9'h000);
                    #1;
                    rst_n = 1'b1;
                    #1;
                    chk("mid_rel", {finalcarry, sum}, 9'h000);
                end
                @(posedge clk);
                #1;
                exp_q = 9'(ia) + 9'(ib);
                chk("exh", {finalcarry, sum}, exp_q);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
